// File: rtl/riscv_pkg.sv
// Shared encodings for the RISC-V execute stage: ALU operations and forward-select codes.
package riscv_pkg;

    localparam int unsigned ALU_OP_W   = 3;
    localparam int unsigned FWD_W      = 2;
    localparam int unsigned REG_ADDR_W = 5;

    localparam logic [ALU_OP_W-1:0] ALU_ADD = 3'b000;
    localparam logic [ALU_OP_W-1:0] ALU_SUB = 3'b001;
    localparam logic [ALU_OP_W-1:0] ALU_AND = 3'b010;
    localparam logic [ALU_OP_W-1:0] ALU_OR  = 3'b011;
    localparam logic [ALU_OP_W-1:0] ALU_SLT = 3'b101;

    localparam logic [FWD_W-1:0] FWD_REG = 2'b00;
    localparam logic [FWD_W-1:0] FWD_WB  = 2'b01;
    localparam logic [FWD_W-1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/execute_cycle_alu.sv
// Combinational ALU for the execute stage; unsupported operation codes yield zero.
module alu
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0]     A,
    input  logic [XLEN-1:0]     B,
    input  logic [ALU_OP_W-1:0] ALUControl,
    output logic [XLEN-1:0]     Result,
    output logic                Zero
);

    always_comb begin
        Result = '0;
        case (ALUControl)
            ALU_ADD: Result = A + B;
            ALU_SUB: Result = A - B;
            ALU_AND: Result = A & B;
            ALU_OR:  Result = A | B;
            ALU_SLT: Result = XLEN'($signed(A) < $signed(B));
            default: Result = '0;
        endcase
    end

    assign Zero = (Result == '0);

endmodule

// File: rtl/execute_cycle.sv
// Execute stage: operand forwarding, ALU, beq resolution and the EX/MEM pipeline register.
// Optional operand forwarding is enabled by defining FORWARDING_EN.
module execute_cycle
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  RegWriteE,
    input  logic                  ALUSrcE,
    input  logic                  MemWriteE,
    input  logic                  ResultSrcE,
    input  logic                  BranchE,
    input  logic [ALU_OP_W-1:0]   ALUControlE,
    input  logic [XLEN-1:0]       RD1_E,
    input  logic [XLEN-1:0]       RD2_E,
    input  logic [XLEN-1:0]       Imm_Ext_E,
    input  logic [XLEN-1:0]       PCE,
    input  logic [XLEN-1:0]       PCPlus4E,
    input  logic [REG_ADDR_W-1:0] RD_E,
    input  logic [REG_ADDR_W-1:0] Rs1_E,
    input  logic [REG_ADDR_W-1:0] Rs2_E,
    input  logic [FWD_W-1:0]      ForwardA_E,
    input  logic [FWD_W-1:0]      ForwardB_E,
    input  logic [XLEN-1:0]       ResultW,
    output logic                  PCSrcE,
    output logic [XLEN-1:0]       PCTargetE,
    output logic                  RegWriteM,
    output logic                  MemWriteM,
    output logic                  ResultSrcM,
    output logic [REG_ADDR_W-1:0] RD_M,
    output logic [XLEN-1:0]       ALUResultM,
    output logic [XLEN-1:0]       WriteDataM,
    output logic [XLEN-1:0]       PCPlus4M
);

    logic [XLEN-1:0] w_src_a;
    logic [XLEN-1:0] w_fwd_b;
    logic [XLEN-1:0] w_src_b;
    logic [XLEN-1:0] w_alu_result;
    logic            w_zero;
    logic            w_unused;

`ifdef FORWARDING_EN
    // Forward source 10 reads ALUResultM as it stood before the coming edge.
    always_comb begin
        w_src_a = RD1_E;
        case (ForwardA_E)
            FWD_WB:  w_src_a = ResultW;
            FWD_MEM: w_src_a = ALUResultM;
            default: w_src_a = RD1_E;
        endcase
    end

    always_comb begin
        w_fwd_b = RD2_E;
        case (ForwardB_E)
            FWD_WB:  w_fwd_b = ResultW;
            FWD_MEM: w_fwd_b = ALUResultM;
            default: w_fwd_b = RD2_E;
        endcase
    end

    assign w_unused = ^{Rs1_E, Rs2_E};
`else
    assign w_src_a  = RD1_E;
    assign w_fwd_b  = RD2_E;
    assign w_unused = ^{Rs1_E, Rs2_E, ForwardA_E, ForwardB_E, ResultW};
`endif

    assign w_src_b = ALUSrcE ? Imm_Ext_E : w_fwd_b;

    alu #(
        .XLEN (XLEN)
    ) u_alu (
        .A          (w_src_a),
        .B          (w_src_b),
        .ALUControl (ALUControlE),
        .Result     (w_alu_result),
        .Zero       (w_zero)
    );

    // Branch target is computed unconditionally; only PCSrcE depends on BranchE.
    assign PCSrcE    = BranchE & w_zero;
    assign PCTargetE = PCE + Imm_Ext_E;

    // Store data is the forwarded B operand, never the immediate.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            RegWriteM  <= 1'b0;
            MemWriteM  <= 1'b0;
            ResultSrcM <= 1'b0;
            RD_M       <= '0;
            ALUResultM <= '0;
            WriteDataM <= '0;
            PCPlus4M   <= '0;
        end else begin
            RegWriteM  <= RegWriteE;
            MemWriteM  <= MemWriteE;
            ResultSrcM <= ResultSrcE;
            RD_M       <= RD_E;
            ALUResultM <= w_alu_result;
            WriteDataM <= w_fwd_b;
            PCPlus4M   <= PCPlus4E;
        end
    end

endmodule

// File: tb/tb_execute_cycle.sv
// Directed, table-driven bench for execute_cycle, with hand sequences for reset and forwarding.
module tb_execute_cycle;

    logic        clk = 1'b0;
    logic        rst;
    logic        RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE;
    logic [2:0]  ALUControlE;
    logic [31:0] RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, ResultW;
    logic [4:0]  RD_E, Rs1_E, Rs2_E;
    logic [1:0]  ForwardA_E, ForwardB_E;
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic        RegWriteM, MemWriteM, ResultSrcM;
    logic [4:0]  RD_M;
    logic [31:0] ALUResultM, WriteDataM, PCPlus4M;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    execute_cycle #(.XLEN(32)) dut (
        .clk(clk), .rst(rst),
        .RegWriteE(RegWriteE), .ALUSrcE(ALUSrcE), .MemWriteE(MemWriteE),
        .ResultSrcE(ResultSrcE), .BranchE(BranchE), .ALUControlE(ALUControlE),
        .RD1_E(RD1_E), .RD2_E(RD2_E), .Imm_Ext_E(Imm_Ext_E),
        .PCE(PCE), .PCPlus4E(PCPlus4E),
        .RD_E(RD_E), .Rs1_E(Rs1_E), .Rs2_E(Rs2_E),
        .ForwardA_E(ForwardA_E), .ForwardB_E(ForwardB_E), .ResultW(ResultW),
        .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
        .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
        .RD_M(RD_M), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M)
    );

    typedef struct {
        logic [2:0]  op;
        logic        alusrc;
        logic        branch;
        logic        memwrite;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [31:0] pce;
        logic [31:0] e_alu;
        logic [31:0] e_wd;
        logic        e_pcsrc;
        logic [31:0] e_tgt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [2:0] op, input logic alusrc, input logic branch,
                                input logic memwrite, input logic [31:0] rd1, input logic [31:0] rd2,
                                input logic [31:0] imm, input logic [31:0] pce,
                                input logic [31:0] e_alu, input logic [31:0] e_wd,
                                input logic e_pcsrc, input logic [31:0] e_tgt);
        vec_t v;
        v.op = op; v.alusrc = alusrc; v.branch = branch; v.memwrite = memwrite;
        v.rd1 = rd1; v.rd2 = rd2; v.imm = imm; v.pce = pce;
        v.e_alu = e_alu; v.e_wd = e_wd; v.e_pcsrc = e_pcsrc; v.e_tgt = e_tgt;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [2:0] op, input logic alusrc, input logic branch,
                         input logic memwrite, input logic [31:0] rd1, input logic [31:0] rd2,
                         input logic [31:0] imm, input logic [31:0] pce, input logic [4:0] rd,
                         input logic [1:0] fa, input logic [1:0] fb, input logic [31:0] rw);
        ALUControlE = op; ALUSrcE = alusrc; BranchE = branch; MemWriteE = memwrite;
        RD1_E = rd1; RD2_E = rd2; Imm_Ext_E = imm; PCE = pce; PCPlus4E = pce + 32'd4;
        RD_E = rd; RegWriteE = rd[0]; ResultSrcE = rd[1];
        ForwardA_E = fa; ForwardB_E = fb; ResultW = rw;
    endtask

    // One cycle of a table vector: combinational checks before the edge, registered after.
    task automatic run_vec(input vec_t v, input int idx);
        logic [4:0] rd;
        rd = 5'(idx + 1);
        @(negedge clk);
        drive(v.op, v.alusrc, v.branch, v.memwrite, v.rd1, v.rd2, v.imm, v.pce, rd,
              2'b00, 2'b00, 32'hDEAD_0000);
        #1;
        check($sformatf("v%0d PCSrcE", idx), {31'd0, PCSrcE}, {31'd0, v.e_pcsrc});
        check($sformatf("v%0d PCTargetE", idx), PCTargetE, v.e_tgt);
        @(posedge clk);
        #1;
        check($sformatf("v%0d ALUResultM", idx), ALUResultM, v.e_alu);
        check($sformatf("v%0d WriteDataM", idx), WriteDataM, v.e_wd);
        check($sformatf("v%0d MemWriteM", idx), {31'd0, MemWriteM}, {31'd0, v.memwrite});
        check($sformatf("v%0d RD_M", idx), {27'd0, RD_M}, {27'd0, rd});
        check($sformatf("v%0d RegWriteM", idx), {31'd0, RegWriteM}, {31'd0, rd[0]});
        check($sformatf("v%0d ResultSrcM", idx), {31'd0, ResultSrcM}, {31'd0, rd[1]});
        check($sformatf("v%0d PCPlus4M", idx), PCPlus4M, v.pce + 32'd4);
    endtask

    task automatic check_m_zero(input string tag);
        check({tag, " RegWriteM"}, {31'd0, RegWriteM}, 32'd0);
        check({tag, " MemWriteM"}, {31'd0, MemWriteM}, 32'd0);
        check({tag, " ResultSrcM"}, {31'd0, ResultSrcM}, 32'd0);
        check({tag, " RD_M"}, {27'd0, RD_M}, 32'd0);
        check({tag, " ALUResultM"}, ALUResultM, 32'd0);
        check({tag, " WriteDataM"}, WriteDataM, 32'd0);
        check({tag, " PCPlus4M"}, PCPlus4M, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        Rs1_E = 5'd3; Rs2_E = 5'd4;

        //                op      src   br    mw    rd1           rd2           imm           pce           e_alu         e_wd          pcsrc e_tgt
        vecs.push_back(mk(3'b000, 1'b0, 1'b0, 1'b0, 32'd5,        32'd3,        32'd0,        32'h100,      32'd8,        32'd3,        1'b0, 32'h100));
        vecs.push_back(mk(3'b001, 1'b0, 1'b0, 1'b0, 32'd5,        32'd3,        32'd4,        32'h100,      32'd2,        32'd3,        1'b0, 32'h104));
        vecs.push_back(mk(3'b101, 1'b0, 1'b0, 1'b0, 32'hFFFFFFFF, 32'd3,        32'd0,        32'h0,        32'd1,        32'd3,        1'b0, 32'h0));
        vecs.push_back(mk(3'b101, 1'b0, 1'b0, 1'b0, 32'd5,        32'd3,        32'd0,        32'h0,        32'd0,        32'd3,        1'b0, 32'h0));
        vecs.push_back(mk(3'b101, 1'b0, 1'b0, 1'b0, 32'h80000000, 32'h7FFFFFFF, 32'd0,        32'h0,        32'd1,        32'h7FFFFFFF, 1'b0, 32'h0));
        vecs.push_back(mk(3'b000, 1'b0, 1'b0, 1'b0, 32'h7FFFFFFF, 32'd1,        32'd0,        32'h0,        32'h80000000, 32'd1,        1'b0, 32'h0));
        vecs.push_back(mk(3'b001, 1'b0, 1'b0, 1'b0, 32'd0,        32'd1,        32'd0,        32'h0,        32'hFFFFFFFF, 32'd1,        1'b0, 32'h0));
        vecs.push_back(mk(3'b010, 1'b0, 1'b0, 1'b0, 32'h0000F0F0, 32'h0000FF00, 32'd0,        32'h0,        32'h0000F000, 32'h0000FF00, 1'b0, 32'h0));
        vecs.push_back(mk(3'b011, 1'b0, 1'b0, 1'b0, 32'h0000F0F0, 32'h0000FF00, 32'd0,        32'h0,        32'h0000FFF0, 32'h0000FF00, 1'b0, 32'h0));
        vecs.push_back(mk(3'b100, 1'b0, 1'b0, 1'b0, 32'd5,        32'd3,        32'd0,        32'h0,        32'd0,        32'd3,        1'b0, 32'h0));
        vecs.push_back(mk(3'b110, 1'b0, 1'b1, 1'b0, 32'd5,        32'd3,        32'd8,        32'h10,       32'd0,        32'd3,        1'b1, 32'h18));
        vecs.push_back(mk(3'b111, 1'b0, 1'b0, 1'b0, 32'd5,        32'd3,        32'd0,        32'h0,        32'd0,        32'd3,        1'b0, 32'h0));
        vecs.push_back(mk(3'b000, 1'b1, 1'b0, 1'b1, 32'h100,      32'hABCD,     32'h10,       32'h200,      32'h110,      32'hABCD,     1'b0, 32'h210));
        vecs.push_back(mk(3'b001, 1'b0, 1'b1, 1'b0, 32'd7,        32'd7,        32'hFFFFFFF8, 32'h40,       32'd0,        32'd7,        1'b1, 32'h38));
        vecs.push_back(mk(3'b001, 1'b0, 1'b1, 1'b0, 32'd7,        32'd6,        32'hFFFFFFF8, 32'h40,       32'd1,        32'd6,        1'b0, 32'h38));
        vecs.push_back(mk(3'b001, 1'b0, 1'b0, 1'b0, 32'd7,        32'd7,        32'hFFFFFFF8, 32'h40,       32'd0,        32'd7,        1'b0, 32'h38));
        vecs.push_back(mk(3'b000, 1'b0, 1'b0, 1'b0, 32'hFFFFFFFF, 32'd1,        32'h1,        32'hFFFFFFFF, 32'd0,        32'd1,        1'b0, 32'h0));

        // Reset held with non-zero inputs and a running clock.
        rst = 1'b0;
        drive(3'b000, 1'b0, 1'b0, 1'b1, 32'd5, 32'd3, 32'h10, 32'h80, 5'd7, 2'b00, 2'b00, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        check_m_zero("reset");
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("post-reset ALUResultM", ALUResultM, 32'd8);
        check("post-reset RD_M", {27'd0, RD_M}, 32'd7);

        foreach (vecs[i]) run_vec(vecs[i], i);

        // Back-to-back identical instructions.
        run_vec(vecs[0], 100);
        run_vec(vecs[0], 100);

        // Asynchronous reset mid-cycle clears outputs without a clock edge.
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check_m_zero("async-reset");
        @(negedge clk);
        rst = 1'b1;

        // Forwarding sequences: set up ALUResultM = 0x20, then consume it.
        @(negedge clk);
        drive(3'b000, 1'b0, 1'b0, 1'b0, 32'h10, 32'h10, 32'h0, 32'h0, 5'd1, 2'b00, 2'b00, 32'h0);
        @(posedge clk); #1;
        check("fwd setup ALUResultM", ALUResultM, 32'h20);
        @(negedge clk);
        drive(3'b000, 1'b0, 1'b0, 1'b0, 32'h999, 32'd1, 32'h0, 32'h0, 5'd2, 2'b10, 2'b00, 32'h0);
        @(posedge clk); #1;
`ifdef FORWARDING_EN
        check("fwdA MEM ALUResultM", ALUResultM, 32'h21);
`else
        check("fwdA MEM ALUResultM", ALUResultM, 32'h99A);
`endif
        // Chained MEM forward: previous result feeds the next add.
        @(negedge clk);
        drive(3'b000, 1'b0, 1'b0, 1'b0, 32'h5, 32'd2, 32'h0, 32'h0, 5'd2, 2'b10, 2'b10, 32'h0);
        @(posedge clk); #1;
`ifdef FORWARDING_EN
        check("fwdAB MEM ALUResultM", ALUResultM, 32'h42);
        check("fwdAB MEM WriteDataM", WriteDataM, 32'h21);
`else
        check("fwdAB MEM ALUResultM", ALUResultM, 32'h7);
        check("fwdAB MEM WriteDataM", WriteDataM, 32'h2);
`endif
        @(negedge clk);
        drive(3'b000, 1'b0, 1'b0, 1'b1, 32'h0, 32'h77, 32'h0, 32'h0, 5'd3, 2'b00, 2'b01, 32'h55);
        @(posedge clk); #1;
`ifdef FORWARDING_EN
        check("fwdB WB ALUResultM", ALUResultM, 32'h55);
        check("fwdB WB WriteDataM", WriteDataM, 32'h55);
`else
        check("fwdB WB ALUResultM", ALUResultM, 32'h77);
        check("fwdB WB WriteDataM", WriteDataM, 32'h77);
`endif
        @(negedge clk);
        drive(3'b000, 1'b1, 1'b0, 1'b1, 32'h1, 32'h77, 32'h8, 32'h0, 5'd4, 2'b01, 2'b01, 32'h100);
        @(posedge clk); #1;
`ifdef FORWARDING_EN
        check("fwd WB+imm ALUResultM", ALUResultM, 32'h108);
        check("fwd WB+imm WriteDataM", WriteDataM, 32'h100);
`else
        check("fwd WB+imm ALUResultM", ALUResultM, 32'h9);
        check("fwd WB+imm WriteDataM", WriteDataM, 32'h77);
`endif
        @(negedge clk);
        drive(3'b000, 1'b0, 1'b0, 1'b0, 32'h3, 32'h4, 32'h0, 32'h0, 5'd5, 2'b11, 2'b11, 32'h55);
        @(posedge clk); #1;
        check("fwd sel11 ALUResultM", ALUResultM, 32'h7);
        check("fwd sel11 WriteDataM", WriteDataM, 32'h4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/execute_cycle.md
# execute_cycle

Execute stage of the pipelined RISC-V core. Consumes the ID/EX pipeline register outputs of the decode stage, selects operands with optional forwarding, and runs the ALU. Resolves `beq` branches combinationally and registers results into the EX/MEM pipeline register feeding the memory stage.

## Interface

Parameters:
- `XLEN`, default 32: datapath width.

Ports (one clock; reset is asynchronous and active-low):
- `clk` input 1: rising-edge clock.
- `rst` input 1: asynchronous active-low reset.
- `RegWriteE`, `ALUSrcE`, `MemWriteE`, `ResultSrcE`, `BranchE` input 1 each: control from ID/EX.
- `ALUControlE` input 3: ALU operation.
- `RD1_E`, `RD2_E` input XLEN: register operands.
- `Imm_Ext_E` input XLEN: immediate value.
- `PCE`, `PCPlus4E` input XLEN: PC of the instruction, and PC+4.
- `RD_E`, `Rs1_E`, `Rs2_E` input 5: destination register and source registers.
- `ForwardA_E`, `ForwardB_E` input 2: forwarding selects from the hazard unit.
- `ResultW` input XLEN: writeback result, used for forwarding.
- `PCSrcE` output 1: branch taken (combinational).
- `PCTargetE` output XLEN: branch target (combinational).
- `RegWriteM`, `MemWriteM`, `ResultSrcM` output 1 each: registered control.
- `RD_M` output 5: registered destination register.
- `ALUResultM`, `WriteDataM`, `PCPlus4M` output XLEN: registered ALU result, store data and PC+4.

## Operation

- Operand A, per `ForwardA_E`:
  - 00: `RD1_E`
  - 01: `ResultW`
  - 10: `ALUResultM` (internal feedback)
  - 11: reserved, treated as 00.
- Forwarded B is selected by `ForwardB_E` with the same encoding, starting from `RD2_E`.
- SrcB = `ALUSrcE` ? `Imm_Ext_E` : forwarded B.
- ALU operations:
  - 000 add
  - 001 sub
  - 010 and
  - 011 or
  - 101 slt (signed; result 1 or 0)
  - any other code produces 0
- Add and sub wrap modulo 2^XLEN; no overflow trap.
- `Zero` = (ALU result == 0).
- `PCSrcE` = `BranchE` & `Zero`.
- `PCTargetE` = `PCE` + `Imm_Ext_E`, modulo 2^XLEN. It is computed even when `BranchE` = 0.
- The EX/MEM register captures on every rising edge with no stall or enable:
  - `RegWriteE`→`RegWriteM`, `MemWriteE`→`MemWriteM`, `ResultSrcE`→`ResultSrcM`, `RD_E`→`RD_M`, `PCPlus4E`→`PCPlus4M`
  - ALU result→`ALUResultM`
  - forwarded B (never the immediate)→`WriteDataM`
- The Rs1/Rs2 inputs only feed hazard detection externally and are not registered here.

## Timing

- Reset value of every registered output is 0 (`RegWriteM`, `MemWriteM`, `ResultSrcM`, `RD_M`, `ALUResultM`, `WriteDataM`, `PCPlus4M`).
- Reset asserted mid-operation clears the registered outputs immediately, independent of `clk`. After release, the first rising edge captures the current inputs.
- `PCSrcE` and `PCTargetE` are purely combinational, with zero-cycle latency from the E inputs.
- EX→M latency is one cycle.
- Forward source 10 uses the value of `ALUResultM` before the current edge (back-to-back dependency). On the edge the old value is consumed and the new value is written; there is no conflict.
- Back-to-back identical instructions must produce identical M outputs on consecutive cycles.

## Configuration

- `FORWARDING_EN` defined:
  - Forwarding muxes are present as described in Operation.
- Undefined:
  - Operand A = `RD1_E` and forwarded B = `RD2_E`.
  - `ForwardA_E`, `ForwardB_E` and `ResultW` remain as ports but are ignored.
  - The `ALUResultM` feedback path is removed.
  - All other behaviour is identical.

## Structure

- Package `riscv_pkg` holds:
  - ALU operation localparams (`ALU_ADD`, `ALU_SUB`, `ALU_AND`, `ALU_OR`, `ALU_SLT`)
  - forward-select encodings (`FWD_REG`, `FWD_WB`, `FWD_MEM`)
- Sub-module `alu`: combinational; ports `A`, `B`, `ALUControl`, `Result`, `Zero`. It is instantiated once.
- Forwarding muxes, branch adder and the EX/MEM register live in `execute_cycle`.

## Test plan

- Reset: assert `rst`=0 with non-zero inputs and toggle `clk` → all M outputs read 0; release, one edge later `ALUResultM` reflects the inputs.
- add/sub/slt: RD1_E=5, RD2_E=3, `ALUSrcE`=0:
  - op 000 → `ALUResultM`=8
  - op 001 → 2
  - op 101 with RD1_E=0xFFFFFFFF → 1
  - 0x7FFFFFFF+1 → 0x80000000 (wrap)
- Immediate and store: `ALUSrcE`=1, `Imm_Ext_E`=0x10, RD1_E=0x100, RD2_E=0xABCD, `MemWriteE`=1 → `ALUResultM`=0x110, `WriteDataM`=0xABCD, `MemWriteM`=1.
- Branch: PCE=0x40, Imm=0xFFFFFFF8, RD1_E=RD2_E=7, `BranchE`=1, op 001 → `PCSrcE`=1 and `PCTargetE`=0x38 in the same cycle. With RD2_E=6 → `PCSrcE`=0.
- Forwarding (`FORWARDING_EN`):
  - cycle n `ALUResultM`=0x20; cycle n+1 `ForwardA_E`=10, RD2_E=1, add → next `ALUResultM`=0x21
  - `ForwardB_E`=01, `ResultW`=0x55 → `WriteDataM`=0x55
  - select 11 → RD values are used
- Forwarding compiled out: same stimulus as the forwarding test → results use the RD1_E/RD2_E values only.
